// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads and buffers words in a prefetch queue.
// Optional FETCH_STATS_EN adds fetch/flush event counters.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0,
   parameter int          DEPTH   = 4,
   parameter int          WORD_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   output logic              imemREN,
   output logic [WORD_W-1:0] imemaddr,
   input  logic              ihit,
   input  logic [WORD_W-1:0] imemload,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_addr,
   input  logic              halt_in,
   output logic              halt,
   input  logic              deq,
   output logic              instr_valid,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] instr_pc,
`ifdef FETCH_STATS_EN
   output logic [31:0]       fetch_count,
   output logic [31:0]       flush_count,
`endif
   output logic [WORD_W-1:0] instr_pcplus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WORD_W-1:0] fetch_pc;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [WORD_W-1:0] q_instr [DEPTH];
   logic [WORD_W-1:0] q_pc    [DEPTH];
   logic              enq;
   logic              deq_en;

   // Redirect blocks the request so a same-cycle ihit can never enqueue.
   assign imemREN  = nRST & ~halt & (count < FULL) & ~redirect;
   assign imemaddr = fetch_pc;
   assign enq      = imemREN & ihit;
   assign deq_en   = deq & instr_valid & ~redirect;

   assign instr_valid  = (count != '0);
   assign instr        = instr_valid ? q_instr[rd_ptr] : '0;
   assign instr_pc     = instr_valid ? q_pc[rd_ptr] : '0;
   assign instr_pcplus = instr_pc + WORD_W'(4);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_pc <= WORD_W'(PC_INIT);
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         halt     <= 1'b0;
      end else begin
         if (halt_in)
            halt <= 1'b1;
         if (redirect) begin
            fetch_pc <= redirect_addr;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (enq) begin
               wr_ptr   <= wr_ptr + PTR_W'(1);
               fetch_pc <= fetch_pc + WORD_W'(4);
            end
            if (deq_en)
               rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq_en)
               count <= count + CNT_W'(1);
            else if (!enq && deq_en)
               count <= count - CNT_W'(1);
         end
      end
   end

   // Queue storage needs no reset; entries are only visible while counted.
   always_ff @(posedge CLK) begin
      if (enq) begin
         q_instr[wr_ptr] <= imemload;
         q_pc[wr_ptr]    <= fetch_pc;
      end
   end

`ifdef FETCH_STATS_EN
   logic [32:0] flush_sum;
   assign flush_sum = {1'b0, flush_count} + 33'(count);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (enq && fetch_count != '1)
            fetch_count <= fetch_count + 32'd1;
         if (redirect)
            flush_count <= flush_sum[32] ? '1 : flush_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, full queue, redirect flush,
// sticky halt, async reset and PC wrap.
module tb_fetch_unit;

   localparam logic [31:0] K = 32'h1357_0000;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        halt_in;
   logic        halt;
   logic        deq;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pcplus;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] flush_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   // Instruction memory model: word content is derived from its address.
   assign imemload = imemaddr ^ K;

   fetch_unit #(.PC_INIT(32'h0), .DEPTH(4), .WORD_W(32)) dut (
      .CLK(CLK),
      .nRST(nRST),
      .imemREN(imemREN),
      .imemaddr(imemaddr),
      .ihit(ihit),
      .imemload(imemload),
      .redirect(redirect),
      .redirect_addr(redirect_addr),
      .halt_in(halt_in),
      .halt(halt),
      .deq(deq),
      .instr_valid(instr_valid),
      .instr(instr),
      .instr_pc(instr_pc),
`ifdef FETCH_STATS_EN
      .fetch_count(fetch_count),
      .flush_count(flush_count),
`endif
      .instr_pcplus(instr_pcplus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0; ihit = 1'b0; deq = 1'b0; redirect = 1'b0;
      redirect_addr = '0; halt_in = 1'b0;
      #12;
      chk("rst_ren", 32'(imemREN), 32'd0);
      chk("rst_addr", imemaddr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_pcplus", instr_pcplus, 32'h4);
      chk("rst_halt", 32'(halt), 32'd0);
`ifdef FETCH_STATS_EN
      chk("rst_fcnt", fetch_count, 32'd0);
      chk("rst_flcnt", flush_count, 32'd0);
`endif

      // Streaming: ihit and deq held high.
      nRST = 1'b1; ihit = 1'b1; deq = 1'b1;
      #1;
      chk("s0_ren", 32'(imemREN), 32'd1);
      chk("s0_addr", imemaddr, 32'h0);
      chk("s0_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("s1_addr", imemaddr, 32'h4);
      chk("s1_valid", 32'(instr_valid), 32'd1);
      chk("s1_pc", instr_pc, 32'h0);
      chk("s1_instr", instr, 32'h0 ^ K);
      chk("s1_pcplus", instr_pcplus, 32'h4);
      tick();
      chk("s2_addr", imemaddr, 32'h8);
      chk("s2_pc", instr_pc, 32'h4);
      chk("s2_instr", instr, 32'h4 ^ K);
      chk("s2_pcplus", instr_pcplus, 32'h8);

      // Asynchronous reset mid-operation with ihit high.
      nRST = 1'b0;
      #1;
      chk("ar_ren", 32'(imemREN), 32'd0);
      chk("ar_addr", imemaddr, 32'h0);
      chk("ar_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("ar_hold", 32'(instr_valid), 32'd0);

      // Fill: deq low, four enqueues 0x0..0xC.
      deq = 1'b0;
      nRST = 1'b1;
      tick();
      tick();
      tick();
      tick();
      chk("f_ren", 32'(imemREN), 32'd0);
      chk("f_addr", imemaddr, 32'h10);
      chk("f_pc", instr_pc, 32'h0);
      deq = 1'b1;
      #1;
      chk("f_nobypass", 32'(imemREN), 32'd0);
      tick();
      chk("f_ren_back", 32'(imemREN), 32'd1);
      chk("f_pc2", instr_pc, 32'h4);
      chk("f_instr2", instr, 32'h4 ^ K);

      // Redirect with three entries queued and a concurrent ihit.
      deq = 1'b0; redirect = 1'b1; redirect_addr = 32'h200;
      #1;
      chk("r_ren", 32'(imemREN), 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("r_valid", 32'(instr_valid), 32'd0);
      chk("r_addr", imemaddr, 32'h200);
`ifdef FETCH_STATS_EN
      chk("r_fcnt", fetch_count, 32'd4);
      chk("r_flcnt", flush_count, 32'd3);
`endif

      // Halt with two entries queued.
      tick();
      halt_in = 1'b1;
      tick();
      halt_in = 1'b0; deq = 1'b1;
      #1;
      chk("h_halt", 32'(halt), 32'd1);
      chk("h_ren", 32'(imemREN), 32'd0);
      chk("h_addr", imemaddr, 32'h208);
      chk("h_pc0", instr_pc, 32'h200);
      chk("h_instr0", instr, 32'h200 ^ K);
      tick();
      chk("h_pc1", instr_pc, 32'h204);
      chk("h_instr1", instr, 32'h204 ^ K);
      tick();
      chk("h_empty", 32'(instr_valid), 32'd0);
      chk("h_sticky", 32'(halt), 32'd1);
      chk("h_ren2", 32'(imemREN), 32'd0);
      redirect = 1'b1; redirect_addr = 32'h300;
      tick();
      redirect = 1'b0;
      #1;
      chk("h_redir", imemaddr, 32'h300);
      chk("h_ren3", 32'(imemREN), 32'd0);
      chk("h_sticky2", 32'(halt), 32'd1);

      // PC wrap past 0xFFFFFFFC after a fresh reset.
      nRST = 1'b0; deq = 1'b0; ihit = 1'b0;
      #3;
      chk("w_halt_clr", 32'(halt), 32'd0);
      nRST = 1'b1; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0; ihit = 1'b1;
      #1;
      chk("w_addr0", imemaddr, 32'hFFFF_FFFC);
      tick();
      ihit = 1'b0;
      #1;
      chk("w_addr1", imemaddr, 32'h0);
      chk("w_pc", instr_pc, 32'hFFFF_FFFC);
      chk("w_pcplus", instr_pcplus, 32'h0);
`ifdef FETCH_STATS_EN
      chk("w_fcnt", fetch_count, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
